stopwatch_bcd_timer: RTL and testbench

//  Stopwatch timekeeping core feeding the 4-digit 7-segment display driver.

---
 rtl/stopwatch_bcd_timer.sv | 159 +++++++++++++++
 tb/tb_stopwatch_bcd_timer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_timer.sv
// Stopwatch timekeeping core: counts elapsed time as 4 packed BCD digits (SS.hh),
// with start/stop, clear and lap (display freeze) controls driven by 1-cycle pulses.
// Ports:
//   clk        board clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   start_stop 1-cycle pulse, toggles running/halted
//   clear      1-cycle pulse, back to IDLE with 00.00
//   lap        1-cycle pulse, freezes/unfreezes the displayed value
//   number     packed BCD {tens-s, s, tenths, hundredths} for the display driver
//   running    high while elapsed time is advancing (RUNNING or LAP)
//   overflow   sticky, set when time saturates at 99.99
module stopwatch_bcd_timer #(
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned TICK_RATE_IN_HZ             = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] number,
  output logic        running,
  output logic        overflow
);

  localparam int unsigned CYCLES_PER_TICK = BOARD_CLOCK_FREQUENCY_IN_HZ / TICK_RATE_IN_HZ;
  localparam int unsigned PRE_W = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_TICK - 1);
  localparam logic [15:0] COUNT_MAX = 16'h9999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    LAP     = 2'd2,
    PAUSED  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [15:0]      count, count_next;
  logic [15:0]      lap_reg, lap_next;
  logic [PRE_W-1:0] prescaler, pre_next;
  logic             overflow_next;
  logic [15:0]      number_next;
  logic             running_next;
  logic             advancing;
  logic             tick;
  logic             saturate;

  // Increment a 4-digit packed BCD value, each digit wrapping 9->0 with carry.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign advancing = (state == RUNNING) || (state == LAP);

  // State and datapath registers; outputs are registered from their next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= 16'h0000;
      lap_reg   <= 16'h0000;
      prescaler <= '0;
      overflow  <= 1'b0;
      number    <= 16'h0000;
      running   <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      lap_reg   <= lap_next;
      prescaler <= pre_next;
      overflow  <= overflow_next;
      number    <= number_next;
      running   <= running_next;
    end
  end

  // Next-state, prescaler, BCD count and control-pulse handling.
  always_comb begin
    state_next    = state;
    count_next    = count;
    lap_next      = lap_reg;
    pre_next      = prescaler;
    overflow_next = overflow;
    tick          = 1'b0;
    saturate      = 1'b0;

    // Prescaler only moves while time advances; it holds in PAUSED.
    if (advancing) begin
      if (prescaler == PRE_LAST) begin
        tick     = 1'b1;
        pre_next = '0;
      end else begin
        pre_next = prescaler + PRE_W'(1);
      end
    end

    // Tick is applied first so a coincident stop still keeps it.
    if (tick) begin
      if (count == COUNT_MAX) begin
        saturate      = 1'b1;
        overflow_next = 1'b1;
        state_next    = PAUSED;
      end else begin
        count_next = bcd_inc(count);
      end
    end

    // Priority clear > start_stop > lap; saturation overrides the lower two.
    if (clear) begin
      state_next    = IDLE;
      count_next    = 16'h0000;
      lap_next      = 16'h0000;
      pre_next      = '0;
      overflow_next = 1'b0;
    end else if (!saturate) begin
      if (start_stop) begin
        case (state)
          IDLE: begin
            state_next = RUNNING;
            pre_next   = '0;
          end
          RUNNING: state_next = PAUSED;
          LAP:     state_next = PAUSED;
          PAUSED: begin
            if (!overflow) state_next = RUNNING;
          end
          default: state_next = IDLE;
        endcase
      end else if (lap) begin
        case (state)
          RUNNING: begin
            state_next = LAP;
            lap_next   = count;
          end
          LAP:     state_next = RUNNING;
          default: state_next = state;
        endcase
      end
    end

    number_next  = (state_next == LAP) ? lap_next : count_next;
    running_next = (state_next == RUNNING) || (state_next == LAP);
  end

endmodule

// File: tb/tb_stopwatch_bcd_timer.sv
// Directed self-checking bench for stopwatch_bcd_timer.
// dut uses 10 clocks per tick; dut_f uses 2 clocks per tick to reach 99.99 quickly.
module tb_stopwatch_bcd_timer;

  logic        clk;
  logic        rst_n;
  logic        start_stop;
  logic        clear;
  logic        lap;
  logic [15:0] number;
  logic        running;
  logic        overflow;
  logic [15:0] number_f;
  logic        running_f;
  logic        overflow_f;

  int n_cmp;
  int n_fail;

  stopwatch_bcd_timer #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(1000),
    .TICK_RATE_IN_HZ(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap),
    .number(number), .running(running), .overflow(overflow)
  );

  stopwatch_bcd_timer #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(200),
    .TICK_RATE_IN_HZ(100)
  ) dut_f (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap),
    .number(number_f), .running(running_f), .overflow(overflow_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic c, input logic l);
    start_stop = s;
    clear      = c;
    lap        = l;
    step(1);
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;

    // Reset state
    step(2);
    check16("rst_number", number, 16'h0000);
    check1("rst_running", running, 1'b0);
    check1("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    step(2);
    check16("idle_number", number, 16'h0000);

    // 1: start and run 250 clocks -> 0.25
    pulse(1'b1, 1'b0, 1'b0);
    step(250);
    check16("t1_number", number, 16'h0025);
    check1("t1_running", running, 1'b1);

    // 2: carries 0.09 -> 0.10 and 9.99 -> 10.00
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    step(90);
    check16("t2_0009", number, 16'h0009);
    step(10);
    check16("t2_0010", number, 16'h0010);
    step(9890);
    check16("t2_0999", number, 16'h0999);
    step(10);
    check16("t2_1000", number, 16'h1000);

    // 3: pause preserves the partial tick
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    step(54);
    check16("t3_0005", number, 16'h0005);
    pulse(1'b1, 1'b0, 1'b0);
    check1("t3_paused", running, 1'b0);
    step(100);
    check16("t3_hold", number, 16'h0005);
    pulse(1'b1, 1'b0, 1'b0);
    check1("t3_resumed", running, 1'b1);
    step(4);
    check16("t3_before", number, 16'h0005);
    step(2);
    check16("t3_0006", number, 16'h0006);

    // 4: lap freezes display while count advances
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    step(120);
    check16("t4_0012", number, 16'h0012);
    pulse(1'b0, 1'b0, 1'b1);
    check16("t4_lap", number, 16'h0012);
    check1("t4_lap_running", running, 1'b1);
    step(80);
    check16("t4_frozen", number, 16'h0012);
    pulse(1'b0, 1'b0, 1'b1);
    check16("t4_live", number, 16'h0020);
    // start_stop beats lap when both pulse together
    pulse(1'b1, 1'b0, 1'b1);
    check1("t4_prio_running", running, 1'b0);
    check16("t4_prio_number", number, 16'h0020);

    // 5: saturation at 99.99 (fast instance)
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    step(19998);
    check16("t5_9999", number_f, 16'h9999);
    check1("t5_no_ovf_yet", overflow_f, 1'b0);
    step(2);
    check16("t5_sat_number", number_f, 16'h9999);
    check1("t5_overflow", overflow_f, 1'b1);
    check1("t5_running", running_f, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    step(2);
    check1("t5_ss_ignored", running_f, 1'b0);
    check16("t5_ss_number", number_f, 16'h9999);
    pulse(1'b0, 1'b1, 1'b0);
    check16("t5_clr_number", number_f, 16'h0000);
    check1("t5_clr_overflow", overflow_f, 1'b0);
    check1("t5_clr_running", running_f, 1'b0);

    // Tick coincident with stop is still applied
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    step(9);
    check16("tk_before", number, 16'h0000);
    pulse(1'b1, 1'b0, 1'b0);
    check16("tk_applied", number, 16'h0001);
    check1("tk_halted", running, 1'b0);
    step(30);
    check16("tk_hold", number, 16'h0001);

    // 6: clear beats start_stop; async reset mid-count
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    step(35);
    check16("t6_0003", number, 16'h0003);
    pulse(1'b1, 1'b1, 1'b0);
    check16("t6_clr_number", number, 16'h0000);
    check1("t6_clr_running", running, 1'b0);
    step(20);
    check16("t6_idle", number, 16'h0000);
    pulse(1'b1, 1'b0, 1'b0);
    step(47);
    check16("t6_0004", number, 16'h0004);
    check1("t6_running", running, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check16("t6_arst_number", number, 16'h0000);
    check1("t6_arst_running", running, 1'b0);
    check1("t6_arst_overflow", overflow, 1'b0);
    check16("t6_arst_number_f", number_f, 16'h0000);
    check1("t6_arst_running_f", running_f, 1'b0);
    step(2);
    rst_n = 1'b1;
    step(30);
    check16("t6_post_rst", number, 16'h0000);
    check1("t6_post_rst_running", running, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
